// File: rtl/asi_usr_ram.sv
// asi_usr_ram: byte-strobed word memory slave for the AXI user bus with a fixed read latency,
// range/collision error flags and saturating access counters.
module asi_usr_ram #(
  parameter int                AXI_DW    = 128,
  parameter int                AXI_AW    = 40,
  parameter int                SLV_WS    = 2,
  parameter int                MEM_DEPTH = 256,
  parameter logic [AXI_AW-1:0] BASE_ADDR = '0,
  parameter int                CNTW      = 16
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset_n,
  input  logic [AXI_AW-1:0]     m_addr,
  input  logic [AXI_DW-1:0]     m_wdata,
  input  logic [AXI_DW/8-1:0]   m_wstrb,
  input  logic                  m_we,
  input  logic                  m_re,
  output logic [AXI_DW-1:0]     m_rdata,
  input  logic                  clr,
  output logic [CNTW-1:0]       wr_cnt,
  output logic [CNTW-1:0]       rd_cnt,
  output logic                  oor_err,
  output logic                  col_err
);
  localparam int BYTES = AXI_DW / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_DEPTH);
  localparam int PS    = SLV_WS > 1 ? SLV_WS - 1 : 1;

  logic [AXI_DW-1:0] r_mem [MEM_DEPTH];
  logic [AXI_AW-1:0] w_off, w_word;
  logic [IW-1:0]     w_idx;
  logic              w_in, w_wr, w_rd;
  logic [AXI_DW-1:0] w_rdata0;
  logic [CNTW-1:0]   r_wr_cnt, r_rd_cnt;
  logic              r_oor, r_col;

  // Full-width subtract: addresses below BASE_ADDR wrap huge and fail the range test.
  always_comb begin
    w_off    = m_addr - BASE_ADDR;
    w_word   = w_off >> OFF;
    w_in     = m_addr >= BASE_ADDR && w_word < AXI_AW'(MEM_DEPTH);
    w_idx    = w_word[IW-1:0];
    w_wr     = m_we && w_in;
    w_rd     = m_re && !m_we && w_in;
    w_rdata0 = w_rd ? r_mem[w_idx] : '0;
  end

  always_ff @(posedge usr_clk)
    if (w_wr)
      for (int i = 0; i < BYTES; i++)
        if (m_wstrb[i]) r_mem[w_idx][8*i +: 8] <= m_wdata[8*i +: 8];

  generate
    if (SLV_WS == 0) begin : g_comb
      assign m_rdata = w_rdata0;
    end else begin : g_pipe
      logic [AXI_DW-1:0] r_d [PS];
      logic [PS-1:0]     r_v;
      logic [AXI_DW-1:0] r_out;
      // Output register only loads when a read slot arrives, so m_rdata holds between reads.
      always_ff @(posedge usr_clk)
        if (!usr_reset_n) begin
          for (int k = 0; k < PS; k++) r_d[k] <= '0;
          r_v   <= '0;
          r_out <= '0;
        end else begin
          r_d[0] <= w_rdata0;
          r_v[0] <= m_re;
          for (int k = 1; k < PS; k++) begin
            r_d[k] <= r_d[k-1];
            r_v[k] <= r_v[k-1];
          end
          if (SLV_WS == 1 ? m_re : r_v[PS-1]) r_out <= SLV_WS == 1 ? w_rdata0 : r_d[PS-1];
        end
      assign m_rdata = r_out;
    end
  endgenerate

  always_ff @(posedge usr_clk)
    if (!usr_reset_n || clr) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_oor    <= 1'b0;
      r_col    <= 1'b0;
    end else begin
      if (w_wr && !(&r_wr_cnt)) r_wr_cnt <= r_wr_cnt + CNTW'(1);
      if (w_rd && !(&r_rd_cnt)) r_rd_cnt <= r_rd_cnt + CNTW'(1);
      if ((m_we || m_re) && !w_in) r_oor <= 1'b1;
      if (m_we && m_re) r_col <= 1'b1;
    end

  assign wr_cnt  = r_wr_cnt;
  assign rd_cnt  = r_rd_cnt;
  assign oor_err = r_oor;
  assign col_err = r_col;
endmodule

// File: tb/tb_asi_usr_ram.sv
// tb_asi_usr_ram: randomized and directed checks of asi_usr_ram against a word-array reference model.
module tb_asi_usr_ram;
  localparam int DW = 128, AW = 40, WS = 2, DEP = 256, CW = 4, NB = 16;
  localparam logic [AW-1:0] BASE = 40'h100;

  logic clk = 0, rst_n = 0, we = 0, re = 0, clr = 0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [NB-1:0] wstrb = '0;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic oor, col;
  int total = 0, bad = 0;
  logic [DW-1:0] mdl [DEP];
  int wr_exp = 0, rd_exp = 0;
  bit oor_exp = 0, col_exp = 0;

  asi_usr_ram #(.AXI_DW(DW), .AXI_AW(AW), .SLV_WS(WS), .MEM_DEPTH(DEP), .BASE_ADDR(BASE), .CNTW(CW)) dut (
    .usr_clk(clk), .usr_reset_n(rst_n), .m_addr(addr), .m_wdata(wdata), .m_wstrb(wstrb),
    .m_we(we), .m_re(re), .m_rdata(rdata), .clr(clr), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
    .oor_err(oor), .col_err(col));

  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] wa(int idx);
    return BASE + AW'(idx * NB);
  endfunction

  function automatic bit in_rng(logic [AW-1:0] a);
    return a >= BASE && (a - BASE) / NB < DEP;
  endfunction

  function automatic logic [CW-1:0] sat(int n);
    return CW'(n > 15 ? 15 : n);
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic access(input bit w, input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] s, output logic [DW-1:0] e);
    int id;
    bit ok;
    ok = in_rng(a);
    id = ok ? int'((a - BASE) / NB) : 0;
    we = w; re = r; addr = a; wdata = d; wstrb = s;
    e = (r && !w && ok) ? mdl[id] : '0;
    if (w && ok)
      for (int i = 0; i < NB; i++) if (s[i]) mdl[id][8*i +: 8] = d[8*i +: 8];
    if ((w || r) && !ok) oor_exp = 1;
    if (w && r) col_exp = 1;
    if (w && ok) wr_exp++;
    else if (r && ok) rd_exp++;
    cyc;
    we = 0; re = 0;
  endtask

  task automatic clear_all;
    clr = 1;
    cyc;
    clr = 0;
    wr_exp = 0; rd_exp = 0; oor_exp = 0; col_exp = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) cyc;
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (wr_cnt !== '0) begin bad++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt); end
    total++; if (rd_cnt !== '0) begin bad++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_cnt); end
    total++; if (oor !== 1'b0) begin bad++; $display("FAIL reset_oor got=%b exp=0", oor); end
    total++; if (col !== 1'b0) begin bad++; $display("FAIL reset_col got=%b exp=0", col); end
    rst_n = 1;
    cyc;
  endtask

  task automatic test_strobe;
    logic [DW-1:0] e;
    clear_all;
    access(1, 0, BASE + 40'h10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, e);
    access(1, 0, BASE + 40'h10, {DW{1'b1}}, 16'h000F, e);
    access(0, 1, BASE + 40'h10, '0, '0, e);
    total++; if (rdata !== '0) begin bad++; $display("FAIL strobe_early got=%h exp=0", rdata); end
    cyc;
    total++; if (rdata !== 128'h00112233_44556677_8899AABB_FFFFFFFF)
      begin bad++; $display("FAIL strobe_data got=%h exp=00112233445566778899aabbffffffff", rdata); end
    total++; if (wr_cnt !== 4'd2) begin bad++; $display("FAIL strobe_wr_cnt got=%0d exp=2", wr_cnt); end
    total++; if (rd_cnt !== 4'd1) begin bad++; $display("FAIL strobe_rd_cnt got=%0d exp=1", rd_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] e;
    for (int i = 0; i < 8; i++) access(1, 0, wa(i), DW'(i), '1, e);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) access(0, 1, wa(i), '0, '0, e); else cyc;
      if (i >= 1) begin
        total++;
        if (rdata !== DW'(i - 1)) begin bad++; $display("FAIL b2b_slot%0d got=%h exp=%h", i - 1, rdata, DW'(i - 1)); end
      end
    end
  endtask

  task automatic test_oor;
    logic [DW-1:0] e;
    access(1, 0, wa(255), rnd() | DW'(1), '1, e);
    clear_all;
    access(0, 1, wa(DEP), '0, '0, e);
    cyc;
    total++; if (rdata !== '0) begin bad++; $display("FAIL oor_read got=%h exp=0", rdata); end
    access(1, 0, BASE - 40'h10, rnd(), '1, e);
    access(1, 0, wa(DEP), rnd(), '1, e);
    cyc;
    total++; if (oor !== 1'b1) begin bad++; $display("FAIL oor_flag got=%b exp=1", oor); end
    total++; if (wr_cnt !== sat(wr_exp)) begin bad++; $display("FAIL oor_wr_cnt got=%0d exp=%0d", wr_cnt, sat(wr_exp)); end
    total++; if (rd_cnt !== sat(rd_exp)) begin bad++; $display("FAIL oor_rd_cnt got=%0d exp=%0d", rd_cnt, sat(rd_exp)); end
    access(0, 1, wa(0), '0, '0, e);
    cyc;
    total++; if (rdata !== e) begin bad++; $display("FAIL oor_word0 got=%h exp=%h", rdata, e); end
    access(0, 1, wa(255), '0, '0, e);
    cyc;
    total++; if (rdata !== e) begin bad++; $display("FAIL oor_word255 got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_collision;
    logic [DW-1:0] e;
    clear_all;
    access(1, 1, wa(3), {16{8'hA5}}, '1, e);
    cyc;
    total++; if (rdata !== e) begin bad++; $display("FAIL col_slot got=%h exp=%h", rdata, e); end
    total++; if (col !== col_exp) begin bad++; $display("FAIL col_flag got=%b exp=%b", col, col_exp); end
    total++; if (wr_cnt !== sat(wr_exp)) begin bad++; $display("FAIL col_wr_cnt got=%0d exp=%0d", wr_cnt, sat(wr_exp)); end
    total++; if (rd_cnt !== sat(rd_exp)) begin bad++; $display("FAIL col_rd_cnt got=%0d exp=%0d", rd_cnt, sat(rd_exp)); end
    total++; if (oor !== oor_exp) begin bad++; $display("FAIL col_oor got=%b exp=%b", oor, oor_exp); end
    access(0, 1, wa(3), '0, '0, e);
    cyc;
    total++; if (rdata !== {16{8'hA5}}) begin bad++; $display("FAIL col_readback got=%h exp=a5..a5", rdata); end
  endtask

  task automatic test_random;
    logic [DW-1:0] e, last, prev_e;
    bit prev_rd;
    int op, idx;
    clear_all;
    for (int i = 8; i < 16; i++) access(1, 0, wa(i), rnd(), '1, e);
    last = rdata;
    prev_rd = 0;
    prev_e = '0;
    for (int i = 0; i < 200; i++) begin
      op = i == 0 ? 2 : int'($urandom_range(0, 2));
      idx = int'($urandom_range(0, 15));
      if (op == 1) access(1, 0, wa(idx), rnd(), NB'($urandom), e);
      else if (op == 2) access(0, 1, wa(idx) + AW'($urandom_range(0, 15)), '0, '0, e);
      else begin e = '0; cyc; end
      if (prev_rd) last = prev_e;
      if (i > 0) begin
        total++;
        if (rdata !== last) begin bad++; $display("FAIL rand_cycle%0d got=%h exp=%h", i, rdata, last); end
      end
      prev_rd = op == 2;
      prev_e = e;
    end
    cyc;
    total++; if (wr_cnt !== sat(wr_exp)) begin bad++; $display("FAIL rand_wr_cnt got=%0d exp=%0d", wr_cnt, sat(wr_exp)); end
    total++; if (rd_cnt !== sat(rd_exp)) begin bad++; $display("FAIL rand_rd_cnt got=%0d exp=%0d", rd_cnt, sat(rd_exp)); end
  endtask

  task automatic test_saturation;
    logic [DW-1:0] e;
    clear_all;
    for (int i = 0; i < 20; i++) access(1, 0, wa(20 + i), rnd(), '1, e);
    cyc;
    total++; if (wr_cnt !== 4'd15) begin bad++; $display("FAIL sat_wr_cnt got=%0d exp=15", wr_cnt); end
    access(0, 1, wa(DEP + 5), '0, '0, e);
    access(1, 1, wa(40), rnd(), '1, e);
    cyc;
    total++; if (oor !== 1'b1 || col !== 1'b1) begin bad++; $display("FAIL sat_flags_set got=%b%b exp=11", oor, col); end
    clr = 1;
    access(1, 0, wa(41), rnd(), '1, e);
    clr = 0;
    wr_exp = 0; rd_exp = 0; oor_exp = 0; col_exp = 0;
    total++; if (wr_cnt !== 4'd0) begin bad++; $display("FAIL sat_clr_wr got=%0d exp=0", wr_cnt); end
    total++; if (oor !== 1'b0 || col !== 1'b0) begin bad++; $display("FAIL sat_clr_flags got=%b%b exp=00", oor, col); end
  endtask

  task automatic test_reset_mid_read;
    logic [DW-1:0] e;
    access(1, 0, wa(5), rnd() | DW'(1), '1, e);
    access(0, 1, wa(5), '0, '0, e);
    rst_n = 0;
    cyc;
    total++; if (rdata !== '0) begin bad++; $display("FAIL rst_mid_rdata got=%h exp=0", rdata); end
    rst_n = 1;
    wr_exp = 0; rd_exp = 0; oor_exp = 0; col_exp = 0;
    cyc;
    total++; if (rdata !== '0) begin bad++; $display("FAIL rst_mid_stale got=%h exp=0", rdata); end
    total++; if (wr_cnt !== '0) begin bad++; $display("FAIL rst_mid_wr_cnt got=%0d exp=0", wr_cnt); end
    access(0, 1, wa(5), '0, '0, e);
    cyc;
    total++; if (rdata !== e) begin bad++; $display("FAIL rst_mid_keep got=%h exp=%h", rdata, e); end
  endtask

  initial begin
    test_reset;
    test_strobe;
    test_back_to_back;
    test_oor;
    test_collision;
    test_random;
    test_saturation;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
